// File: rtl/mux_scan_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
// Shared types and constants for the 8:1 mux scan sequencer.
//   scan_state_e : sequencer state (IDLE / SCAN)
//   NCH, SELW    : channel count and select width
//   WORD_RST     : value of the assembled word after reset
//   SEL_FIRST/SEL_LAST : first and last mux channel
// -----------------------------------------------------------------------------
package mux_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  localparam int NCH  = 8;
  localparam int SELW = 3;

  localparam logic [NCH-1:0]  WORD_RST  = 8'h00;
  localparam logic [SELW-1:0] SEL_FIRST = 3'd0;
  localparam logic [SELW-1:0] SEL_LAST  = 3'd7;

endpackage

// File: rtl/mux_scan_ctrl_dwell_timer.sv
// -----------------------------------------------------------------------------
// dwell_timer
// Counts the cycles spent on one mux channel and flags the last one.
//   clk, rst : clock and synchronous active-high reset
//   clear    : force the count back to zero (held while the sequencer idles)
//   enable   : count while high
//   tick     : high on the final dwell cycle of the current channel
// -----------------------------------------------------------------------------
module dwell_timer
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNTW  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  logic [CNTW-1:0] cnt_q, cnt_d;

  // Next count: wrap at the last dwell cycle so the next channel starts at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = CNT_ZERO;
    end else if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Dwell counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
// Drives the select of an 8:1 mux, dwells DWELL cycles on each channel,
// samples the mux output on the last dwell cycle and publishes the eight
// samples as one word once the scan completes.
//   clk, rst : clock and synchronous active-high reset
//   start    : request a scan (only looked at while idle)
//   cont     : continuous mode, looked at on each completion edge
//   y_in     : mux output for the current sel
//   sel      : registered mux select
//   busy     : scan in progress
//   done     : one-cycle completion pulse
//   word     : last completed scan, word[k] sampled with sel=k
// -----------------------------------------------------------------------------
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNTW  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            cont,
  input  logic            y_in,
  output logic [SELW-1:0] sel,
  output logic            busy,
  output logic            done,
  output logic [NCH-1:0]  word
);

  localparam logic [SELW-1:0] SEL_ONE = SELW'(1);

  scan_state_e     state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [NCH-1:0]  word_q, word_d;
  logic [NCH-1:0]  shadow_q, shadow_d;
  logic            tick_s;
  logic            timer_clear_s;
  logic            timer_en_s;

  // The timer is parked at zero while idle, so the first channel of a new
  // scan always gets a full dwell.
  assign timer_clear_s = (state_q == IDLE);
  assign timer_en_s    = (state_q == SCAN);

  dwell_timer #(
    .DWELL (DWELL),
    .CNTW  (CNTW)
  ) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear_s),
    .enable (timer_en_s),
    .tick   (tick_s)
  );

  // Next-state logic for the sequencer, select, shadow and output word.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    word_d   = word_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        sel_d = SEL_FIRST;
        if (start) begin
          state_d = SCAN;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      SCAN: begin
        busy_d = 1'b1;
        if (tick_s) begin
          shadow_d[sel_q] = y_in;
          if (sel_q == SEL_LAST) begin
            // Last channel comes straight from y_in: the shadow bit is only
            // written on this same edge.
            word_d = {y_in, shadow_q[NCH-2:0]};
            done_d = 1'b1;
            sel_d  = SEL_FIRST;
            if (cont) begin
              state_d = SCAN;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            sel_d = sel_q + SEL_ONE;
          end
        end else begin
          sel_d = sel_q;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = SEL_FIRST;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer registers; reset aborts any scan in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= SEL_FIRST;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      word_q   <= WORD_RST;
      shadow_q <= WORD_RST;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      word_q   <= word_d;
      shadow_q <= shadow_d;
    end
  end

  assign sel  = sel_q;
  assign busy = busy_q;
  assign done = done_q;
  assign word = word_q;

endmodule
